// File: rtl/mem_arbiter.sv
// Two-port arbiter (fetch / load-store) onto a single variable-latency memory with a watchdog.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed priority (data wins).
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_done,
  output logic              if_err,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_r,
  input  logic [XLEN/8-1:0] d_w,
  output logic              d_done,
  output logic              d_err,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_r,
  output logic [XLEN/8-1:0] m_w,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_rdata
);

  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 1: data port, 0: fetch port
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            m_req_q, m_req_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;
  logic [SW-1:0]   m_r_q, m_r_d;
  logic [SW-1:0]   m_w_q, m_w_d;
  logic            if_done_q, if_done_d, if_err_q, if_err_d;
  logic            d_done_q, d_done_d, d_err_q, d_err_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            win_d;

`ifdef ARB_RR_EN
  // On a tie the port that did not own the last grant wins.
  always_comb win_d = d_req & (~if_req | ~owner_q);
`else
  always_comb win_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wdog_d     = wdog_q;
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_r_d      = m_r_q;
    m_w_d      = m_w_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    d_done_d   = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          owner_d   = win_d;
          m_req_d   = 1'b1;
          m_addr_d  = win_d ? d_addr : if_addr;
          m_wdata_d = win_d ? d_wdata : '0;
          m_r_d     = win_d ? d_r : '1;
          m_w_d     = win_d ? d_w : '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (m_ack) begin
          if (|m_r_q) begin
            if (owner_q) d_rdata_d = m_rdata;
            else         if_rdata_d = m_rdata;
          end
          m_req_d   = 1'b0;
          d_done_d  = owner_q;
          if_done_d = ~owner_q;
          state_d   = StDone;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          m_req_d  = 1'b0;
          d_err_d  = owner_q;
          if_err_d = ~owner_q;
          state_d  = StDone;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      StDone: begin
        wdog_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      wdog_q     <= '0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_r_q      <= '0;
      m_w_q      <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wdog_q     <= wdog_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_r_q      <= m_r_d;
      m_w_q      <= m_w_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      d_done_q   <= d_done_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_r      = m_r_q;
  assign m_w      = m_w_q;
  assign if_done  = if_done_q;
  assign if_err   = if_err_q;
  assign d_done   = d_done_q;
  assign d_err    = d_err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and responses queued at stimulus time,
// checked by a negedge monitor as the DUT produces them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_r = '0, d_w = '0;
  logic        if_done, if_err, d_done, d_err, m_req, m_ack;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_r, m_w;

  logic resp_ack = 1'b0, ack_force = 1'b0, ack_en = 1'b1;
  int   ack_wait = 0, ack_cnt = 0;
  int   checks = 0, errors = 0;

  typedef struct packed {logic is_d; logic [31:0] addr, wdata; logic [3:0] r, w;} grant_t;
  typedef struct packed {logic is_d; logic err; logic [31:0] rdata;} resp_t;
  grant_t grant_q[$];
  resp_t  resp_q[$];
  grant_t cur;
  logic   m_req_prev = 1'b0;
  logic [31:0] mdl_if_rdata = '0, mdl_d_rdata = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
  endfunction

  mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_r(d_r), .d_w(d_w),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_r(m_r), .m_w(m_w),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  assign m_ack   = resp_ack | ack_force;
  assign m_rdata = mem_rd(m_addr);

  // Memory model: ack after ack_wait stall cycles of m_req.
  always @(posedge clk) begin
    #1;
    if (m_req) begin
      resp_ack = ack_en && (ack_cnt == ack_wait);
      ack_cnt++;
    end else begin
      resp_ack = 1'b0;
      ack_cnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_req_prev = 1'b0;
    end else begin
      int    n;
      resp_t e;
      logic  got_d, got_err;
      logic [31:0] got_rd;
      n = int'(if_done) + int'(if_err) + int'(d_done) + int'(d_err);
      if (n > 0) begin
        checks++;
        if (n != 1) begin
          errors++;
          $display("FAIL pulse_onehot: got %0d pulses required 1", n);
        end else if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got d=%b err=%b required none", d_done | d_err,
                   if_err | d_err);
        end else begin
          e       = resp_q.pop_front();
          got_d   = d_done | d_err;
          got_err = if_err | d_err;
          got_rd  = got_d ? d_rdata : if_rdata;
          if ({got_d, got_err} !== {e.is_d, e.err}) begin
            errors++;
            $display("FAIL resp_kind: got d=%b err=%b required d=%b err=%b", got_d, got_err,
                     e.is_d, e.err);
          end
          checks++;
          if (got_rd !== e.rdata) begin
            errors++;
            $display("FAIL resp_rdata: got %h required %h", got_rd, e.rdata);
          end
        end
      end
      if (m_req && !m_req_prev) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got addr %h required none", m_addr);
        end else begin
          cur = grant_q.pop_front();
          if (m_addr !== cur.addr || m_r !== cur.r || m_w !== cur.w ||
              (cur.is_d && m_wdata !== cur.wdata)) begin
            errors++;
            $display("FAIL grant: got a=%h wd=%h r=%h w=%h required a=%h wd=%h r=%h w=%h",
                     m_addr, m_wdata, m_r, m_w, cur.addr, cur.wdata, cur.r, cur.w);
          end
        end
      end else if (m_req) begin
        checks++;
        if (m_addr !== cur.addr || m_r !== cur.r || m_w !== cur.w ||
            (cur.is_d && m_wdata !== cur.wdata)) begin
          errors++;
          $display("FAIL busy_stable: got a=%h r=%h w=%h required a=%h r=%h w=%h",
                   m_addr, m_r, m_w, cur.addr, cur.r, cur.w);
        end
      end
      m_req_prev = m_req;
    end
  end

  function automatic void push_grant(input logic is_d, input logic [31:0] addr, wdata,
                                     input logic [3:0] r, w);
    grant_t g;
    g.is_d  = is_d;
    g.addr  = addr;
    g.wdata = wdata;
    g.r     = is_d ? r : 4'hF;
    g.w     = is_d ? w : 4'h0;
    grant_q.push_back(g);
  endfunction

  function automatic void push_resp(input logic is_d, input logic err, input logic is_rd,
                                    input logic [31:0] addr);
    resp_t e;
    if (!err && is_rd) begin
      if (is_d) mdl_d_rdata = mem_rd(addr);
      else      mdl_if_rdata = mem_rd(addr);
    end
    e.is_d  = is_d;
    e.err   = err;
    e.rdata = is_d ? mdl_d_rdata : mdl_if_rdata;
    resp_q.push_back(e);
  endfunction

  // Drives one access from a negedge; returns stall-inclusive BUSY cycles and completion cycle.
  task automatic run_access(input logic is_d, input logic [31:0] addr, wdata,
                            input logic [3:0] r, w, input int wt, input logic ack_on,
                            input logic exp_err, output int busy, output int lat);
    push_grant(is_d, addr, wdata, r, w);
    push_resp(is_d, exp_err, is_d ? (r != 4'h0) : 1'b1, addr);
    ack_wait = wt;
    ack_en   = ack_on;
    if (is_d) begin
      d_addr = addr; d_wdata = wdata; d_r = r; d_w = w; d_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    busy = 0;
    lat  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_req) busy++;
      if (if_done || if_err || d_done || d_err) begin
        lat = k;
        break;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    ack_en = 1'b1;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no response required one within 60 cycles");
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      ack_force = ~ack_force;
      @(negedge clk);
    end
    ack_force = 1'b0;
    checks++;
    if ({m_req, if_done, if_err, d_done, d_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {m_req, if_done, if_err, d_done, d_err});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h required 0 0", if_rdata, d_rdata);
    end
    checks++;
    if ({m_addr, m_wdata, m_r, m_w} !== 72'h0) begin
      errors++;
      $display("FAIL reset_mbus: got %h %h %h %h required 0", m_addr, m_wdata, m_r, m_w);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_idle;
    ack_force = 1'b1;
    repeat (2) @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_req, if_done, d_done} !== 3'b0) begin
      errors++;
      $display("FAIL ack_idle: got %b required 000", {m_req, if_done, d_done});
    end
  endtask

  task automatic test_fetch;
    int busy, lat;
    run_access(1'b0, 32'h100, 32'h0, 4'h0, 4'h0, 0, 1'b1, 1'b0, busy, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL fetch_latency: got %0d required 2", lat);
    end
    checks++;
    if (if_rdata !== 32'h13) begin
      errors++;
      $display("FAIL fetch_rdata: got %h required 00000013", if_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_store;
    int busy, lat;
    run_access(1'b1, 32'h2000, 32'hDEADBEEF, 4'h0, 4'b0011, 3, 1'b1, 1'b0, busy, lat);
    checks++;
    if (busy !== 4 || lat !== 5) begin
      errors++;
      $display("FAIL store_timing: got busy %0d lat %0d required busy 4 lat 5", busy, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int busy, lat;
    run_access(1'b1, 32'h2100, 32'h0, 4'hF, 4'h0, 0, 1'b0, 1'b1, busy, lat);
    checks++;
    if (busy !== 4 || lat !== 5 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got busy %0d lat %0d m_req %b required 4 5 0", busy, lat, m_req);
    end
    repeat (3) @(negedge clk);
    run_access(1'b1, 32'h2200, 32'h0, 4'hF, 4'h0, 3, 1'b1, 1'b0, busy, lat);
    checks++;
    if (busy !== 4 || lat !== 5) begin
      errors++;
      $display("FAIL ack_at_limit: got busy %0d lat %0d required busy 4 lat 5", busy, lat);
    end
    @(negedge clk);
    run_access(1'b1, 32'h2300, 32'h0, 4'h0, 4'h0, 1, 1'b1, 1'b0, busy, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL no_strobe: got lat %0d required 3", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_busy;
    int busy, lat;
    push_grant(1'b0, 32'h400, 32'h0, 4'h0, 4'h0);
    ack_en  = 1'b0;
    if_addr = 32'h400;
    if_req  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (m_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: got m_req %b required 1", m_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got m_req %b required 0", m_req);
    end
    mdl_if_rdata = '0;
    mdl_d_rdata  = '0;
    if_req = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_done, if_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_done: got %b required 00", {if_done, if_err});
    end
    rst = 1'b0;
    @(negedge clk);
    run_access(1'b0, 32'h500, 32'h0, 4'h0, 4'h0, 1, 1'b1, 1'b0, busy, lat);
    checks++;
    if (lat !== 3 || if_rdata !== mem_rd(32'h500)) begin
      errors++;
      $display("FAIL post_reset_fetch: got lat %0d rdata %h required 3 %h", lat, if_rdata,
               mem_rd(32'h500));
    end
    @(negedge clk);
  endtask

  // Both ports request at once; data makes two reads, re-requesting regap cycles after done.
  task automatic tie_run(input int regap, input logic exp_ddf);
    int d_left = 2, f_left = 1, gap = 0;
    push_grant(1'b1, 32'h3000, 32'h0, 4'hF, 4'h0);
    push_resp(1'b1, 1'b0, 1'b1, 32'h3000);
    if (exp_ddf) begin
      push_grant(1'b1, 32'h3004, 32'h0, 4'hF, 4'h0);
      push_resp(1'b1, 1'b0, 1'b1, 32'h3004);
      push_grant(1'b0, 32'h200, 32'h0, 4'h0, 4'h0);
      push_resp(1'b0, 1'b0, 1'b1, 32'h200);
    end else begin
      push_grant(1'b0, 32'h200, 32'h0, 4'h0, 4'h0);
      push_resp(1'b0, 1'b0, 1'b1, 32'h200);
      push_grant(1'b1, 32'h3004, 32'h0, 4'hF, 4'h0);
      push_resp(1'b1, 1'b0, 1'b1, 32'h3004);
    end
    ack_wait = 0;
    if_addr = 32'h200; if_req = 1'b1;
    d_addr = 32'h3000; d_wdata = '0; d_r = 4'hF; d_w = 4'h0; d_req = 1'b1;
    for (int k = 0; k < 100 && (d_left > 0 || f_left > 0); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (gap > 0) begin
        gap--;
        if (gap == 0) begin
          d_addr = 32'h3004;
          d_req  = 1'b1;
        end
      end
      if (d_done || d_err) begin
        d_req = 1'b0;
        d_left--;
        if (d_left > 0) gap = regap;
      end
      if (if_done || if_err) begin
        if_req = 1'b0;
        f_left--;
      end
    end
    d_req  = 1'b0;
    if_req = 1'b0;
    checks++;
    if (d_left != 0 || f_left != 0 || grant_q.size() != 0) begin
      errors++;
      $display("FAIL tie_gap%0d: got left d=%0d f=%0d grants=%0d required 0 0 0", regap,
               d_left, f_left, grant_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie;
    tie_run(2, 1'b0);
`ifdef ARB_RR_EN
    tie_run(1, 1'b0);
`else
    tie_run(1, 1'b1);
`endif
  endtask

  initial begin
    test_reset;
    test_ack_idle;
    test_fetch;
    test_store;
    test_timeout;
    test_reset_busy;
    test_tie;
    repeat (4) @(negedge clk);
    checks++;
    if (grant_q.size() != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got grants %0d resps %0d required 0 0", grant_q.size(),
               resp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
